// File: rtl/scc_async_channel.sv
// One SCC channel's 8N1 engine: Tx holding register and shifter, 16x-oversampled Rx; all outputs registered.
// Tx starts on the first baud tick after a load; Rx flags a byte one cycle after the stop sample; no backpressure, an unread byte is overwritten (overrun).
module scc_async_channel #(
   parameter int BAUD_DIV = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_empty,
   output logic       tx_all_sent,
   output logic       txd,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_rd,
   output logic       rx_overrun,
   output logic       rx_frame_err,
   input  logic       err_reset
);
   localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic [15:0] div_cnt;
   logic        tick;

   tx_state_t   tx_state;
   logic [7:0]  tx_hold;
   logic [7:0]  tx_shift;
   logic [3:0]  tx_tcnt;
   logic [2:0]  tx_bit;

   rx_state_t   rx_state;
   logic        rx_sync;
   logic        rxs;
   logic        rx_armed;
   logic [7:0]  rx_shift;
   logic [3:0]  rx_tcnt;
   logic [2:0]  rx_bit;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset || tick) div_cnt <= '0;
      else               div_cnt <= div_cnt + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state    <= TX_IDLE;
         tx_hold     <= '0;
         tx_shift    <= '0;
         tx_tcnt     <= '0;
         tx_bit      <= '0;
         txd         <= 1'b1;
         tx_empty    <= 1'b1;
         tx_all_sent <= 1'b1;
      end else begin
         if (tick) begin
            case (tx_state)
               TX_IDLE: begin
                  if (!tx_empty) begin
                     tx_shift <= tx_hold;
                     tx_empty <= 1'b1;
                     txd      <= 1'b0;
                     tx_tcnt  <= '0;
                     tx_state <= TX_START;
                  end
               end
               TX_START: begin
                  tx_tcnt <= tx_tcnt + 4'd1;
                  if (tx_tcnt == 4'd15) begin
                     txd      <= tx_shift[0];
                     tx_bit   <= '0;
                     tx_state <= TX_DATA;
                  end
               end
               TX_DATA: begin
                  tx_tcnt <= tx_tcnt + 4'd1;
                  if (tx_tcnt == 4'd15) begin
                     if (tx_bit == 3'd7) begin
                        txd      <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        txd      <= tx_shift[1];
                        tx_bit   <= tx_bit + 3'd1;
                     end
                  end
               end
               TX_STOP: begin
                  tx_tcnt <= tx_tcnt + 4'd1;
                  if (tx_tcnt == 4'd15) begin
                     // A full holding register chains straight into the next start bit.
                     if (!tx_empty) begin
                        tx_shift <= tx_hold;
                        tx_empty <= 1'b1;
                        txd      <= 1'b0;
                        tx_state <= TX_START;
                     end else begin
                        tx_all_sent <= 1'b1;
                        tx_state    <= TX_IDLE;
                     end
                  end
               end
               default: tx_state <= TX_IDLE;
            endcase
         end
         if (tx_wr) begin
            tx_hold     <= tx_data;
            tx_empty    <= 1'b0;
            tx_all_sent <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_sync <= rxd;
         rxs     <= rx_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state     <= RX_IDLE;
         rx_armed     <= 1'b1;
         rx_shift     <= '0;
         rx_tcnt      <= '0;
         rx_bit       <= '0;
         rx_data      <= '0;
         rx_avail     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (rx_rd) rx_avail <= 1'b0;
         if (err_reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
         end
         if (tick) begin
            case (rx_state)
               RX_IDLE: begin
                  if (rxs) begin
                     rx_armed <= 1'b1;
                  end else if (rx_armed) begin
                     rx_tcnt  <= '0;
                     rx_state <= RX_START;
                  end
               end
               RX_START: begin
                  rx_tcnt <= rx_tcnt + 4'd1;
                  if (rx_tcnt == 4'd7) begin
                     if (rxs) begin
                        rx_state <= RX_IDLE;
                     end else begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= RX_DATA;
                     end
                  end
               end
               RX_DATA: begin
                  rx_tcnt <= rx_tcnt + 4'd1;
                  if (rx_tcnt == 4'd15) begin
                     rx_shift <= {rxs, rx_shift[7:1]};
                     if (rx_bit == 3'd7) rx_state <= RX_STOP;
                     else                rx_bit   <= rx_bit + 3'd1;
                  end
               end
               RX_STOP: begin
                  rx_tcnt <= rx_tcnt + 4'd1;
                  if (rx_tcnt == 4'd15) begin
                     // Disarm until the line returns high so a held break yields one character.
                     rx_data  <= rx_shift;
                     rx_avail <= 1'b1;
                     rx_armed <= 1'b0;
                     rx_state <= RX_IDLE;
                     if (rx_avail && !rx_rd) rx_overrun   <= 1'b1;
                     if (!rxs)               rx_frame_err <= 1'b1;
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_scc_async_channel.sv
// Bench for scc_async_channel at BAUD_DIV=2: Tx waveforms vs. an ideal 8N1 bit stream,
// Rx outputs vs. a byte-level model of delivery, overrun, framing and clear rules.
`timescale 1ns/1ps
module tb_scc_async_channel;
   localparam int BAUD_DIV = 2;
   localparam int BIT      = 16 * BAUD_DIV;
   localparam int FRAME    = 10 * BIT;
   localparam int GAP      = 20 * BAUD_DIV;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_empty;
   logic       tx_all_sent;
   logic       txd;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_avail;
   logic       rx_rd;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       err_reset;

   int checks = 0;
   int errors = 0;

   logic txd_log[$];
   logic emp_log[$];
   logic all_log[$];
   logic exp_wave[$];

   logic [7:0] m_data;
   logic       m_avail;
   logic       m_ovr;
   logic       m_ferr;

   scc_async_channel #(.BAUD_DIV(BAUD_DIV)) dut (
      .clk(clk), .reset(reset),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty), .tx_all_sent(tx_all_sent), .txd(txd),
      .rxd(rxd), .rx_data(rx_data), .rx_avail(rx_avail), .rx_rd(rx_rd),
      .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .err_reset(err_reset)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running, required finished");
      $fatal(1, "watchdog expired");
   end

   function automatic logic frame_level(input logic [7:0] b, input logic stop, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return stop;
      return b[3'(idx - 1)];
   endfunction

   function automatic void add_frame(input logic [7:0] b);
      for (int i = 0; i < 10; i++)
         for (int k = 0; k < BIT; k++) exp_wave.push_back(frame_level(b, 1'b1, i));
   endfunction

   function automatic void m_deliver(input logic [7:0] b, input logic stop, input logic rd_same);
      if (m_avail && !rd_same) m_ovr = 1'b1;
      if (!stop) m_ferr = 1'b1;
      m_data  = b;
      m_avail = 1'b1;
   endfunction

   task automatic pulse_tx(input logic [7:0] b);
      tx_data = b;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic capture(input int n);
      txd_log.delete(); emp_log.delete(); all_log.delete();
      for (int i = 0; i < n; i++) begin
         txd_log.push_back(txd);
         emp_log.push_back(tx_empty);
         all_log.push_back(tx_all_sent);
         @(negedge clk);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int rd_at,
                          output int rise, output bit dropped);
      logic prev;
      prev = rx_avail; rise = -1; dropped = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (!prev && rx_avail && rise < 0) rise = i;
         if (prev && !rx_avail) dropped = 1;
         prev  = rx_avail;
         rxd   = frame_level(b, stop, i / BIT);
         rx_rd = (i == rd_at);
         @(negedge clk);
      end
      rxd = 1'b1; rx_rd = 1'b0;
   endtask

   task automatic rx_gap();
      rxd = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic rd_pulse();
      rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
      m_avail = 1'b0;
   endtask

   task automatic err_pulse();
      err_reset = 1'b1; @(negedge clk); err_reset = 1'b0;
      m_ovr = 1'b0; m_ferr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; tx_wr = 1'b0; tx_data = '0; rxd = 1'b1; rx_rd = 1'b0; err_reset = 1'b0;
      m_data = '0; m_avail = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      @(negedge clk);
      checks++;
      if ({txd, tx_empty, tx_all_sent} !== 3'b111) begin
         errors++; $display("FAIL reset_tx: got %b, required 111", {txd, tx_empty, tx_all_sent});
      end
      checks++;
      if ({rx_data, rx_avail, rx_overrun, rx_frame_err} !== 11'h000) begin
         errors++; $display("FAIL reset_rx: got %h, required 000", {rx_data, rx_avail, rx_overrun, rx_frame_err});
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_tx();
      logic [7:0] bytes [3];
      int f, bad, lows, ones;
      bytes = '{8'hA5, 8'($urandom), 8'($urandom)};
      foreach (bytes[n]) begin
         checks++;
         if (tx_all_sent !== 1'b1) begin
            errors++; $display("FAIL tx_idle_before: got %b, required 1", tx_all_sent);
         end
         pulse_tx(bytes[n]);
         capture(BAUD_DIV + FRAME + 4);
         exp_wave.delete();
         add_frame(bytes[n]);
         f = -1;
         for (int i = 0; i < txd_log.size(); i++) if (f < 0 && txd_log[i] === 1'b0) f = i;
         checks++;
         if (f < 1 || f > BAUD_DIV) begin
            errors++; $display("FAIL tx_start_latency: got %0d cycles, required 1..%0d", f, BAUD_DIV);
            f = 1;
         end
         bad = 0;
         for (int j = 0; j < FRAME; j++) if (txd_log[f + j] !== exp_wave[j]) bad++;
         checks++;
         if (bad != 0 || txd_log[f + FRAME] !== 1'b1) begin
            errors++; $display("FAIL tx_wave %h: got %0d wrong cycles, required 0 (idle after=%b)",
                               bytes[n], bad, txd_log[f + FRAME]);
         end
         lows = 0; ones = 0;
         for (int i = 0; i <= f + FRAME; i++) if (emp_log[i] === 1'b0) lows++;
         for (int i = 0; i < f + FRAME; i++) if (all_log[i] !== 1'b0) ones++;
         checks++;
         if (emp_log[0] !== 1'b0 || lows != f) begin
            errors++; $display("FAIL tx_empty: got low for %0d cycles, required %0d", lows, f);
         end
         checks++;
         if (ones != 0 || all_log[f + FRAME] !== 1'b1) begin
            errors++; $display("FAIL tx_all_sent: got %0d early highs / end=%b, required 0 / 1", ones, all_log[f + FRAME]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int f, bad, ones;
      pulse_tx(8'h01);
      fork
         capture(BAUD_DIV + 3 * FRAME + 4);
         begin
            repeat (12) @(negedge clk);
            pulse_tx(8'h02);
            repeat (400) @(negedge clk);
            pulse_tx(8'h03);
            repeat (3) @(negedge clk);
            pulse_tx(8'h04);
         end
      join
      exp_wave.delete();
      add_frame(8'h01); add_frame(8'h02); add_frame(8'h04);
      f = -1;
      for (int i = 0; i < txd_log.size(); i++) if (f < 0 && txd_log[i] === 1'b0) f = i;
      if (f < 1 || f > BAUD_DIV) f = 1;
      bad = 0;
      for (int j = 0; j < 3 * FRAME; j++) if (txd_log[f + j] !== exp_wave[j]) bad++;
      checks++;
      if (bad != 0 || txd_log[f + 3 * FRAME] !== 1'b1) begin
         errors++; $display("FAIL tx_b2b_overwrite: got %0d wrong cycles, required 0 (stream 01,02,04)", bad);
      end
      ones = 0;
      for (int i = 0; i < f + 3 * FRAME; i++) if (all_log[i] !== 1'b0) ones++;
      checks++;
      if (ones != 0 || all_log[f + 3 * FRAME] !== 1'b1) begin
         errors++; $display("FAIL tx_b2b_all_sent: got %0d early highs / end=%b, required 0 / 1", ones, all_log[f + 3 * FRAME]);
      end
   endtask

   task automatic test_rx_loop();
      logic [7:0] bytes [5];
      int rise; bit dropped;
      bytes = '{8'h3C, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      foreach (bytes[n]) begin
         send_rx(bytes[n], 1'b1, -1, rise, dropped);
         m_deliver(bytes[n], 1'b1, 1'b0);
         checks++;
         if (rise < 304 - (BAUD_DIV + 2) || rise > 304 + BAUD_DIV + 5) begin
            errors++; $display("FAIL rx_avail_timing: got %0d cycles after start edge, required about 304", rise);
         end
         rx_gap();
         checks++;
         if ({rx_data, rx_avail, rx_overrun, rx_frame_err} !== {m_data, m_avail, m_ovr, m_ferr}) begin
            errors++; $display("FAIL rx_loop: got %h, required %h", {rx_data, rx_avail, rx_overrun, rx_frame_err},
                               {m_data, m_avail, m_ovr, m_ferr});
         end
         rd_pulse();
      end
   endtask

   task automatic test_rx_overrun_frame();
      logic [7:0] b;
      int rise; bit dropped;
      for (int n = 0; n < 3; n++) begin
         b = 8'($urandom);
         send_rx(b, (n != 2), -1, rise, dropped);
         m_deliver(b, (n != 2), 1'b0);
         rx_gap();
         if (n > 0) begin
            checks++;
            if ({rx_data, rx_avail, rx_overrun, rx_frame_err} !== {m_data, m_avail, m_ovr, m_ferr}) begin
               errors++; $display("FAIL rx_overrun_frame%0d: got %h, required %h", n,
                                  {rx_data, rx_avail, rx_overrun, rx_frame_err}, {m_data, m_avail, m_ovr, m_ferr});
            end
         end
      end
      err_pulse();
      checks++;
      if ({rx_overrun, rx_frame_err} !== 2'b00 || rx_avail !== 1'b1) begin
         errors++; $display("FAIL err_reset: got ovr/ferr/avail %b%b%b, required 001", rx_overrun, rx_frame_err, rx_avail);
      end
      rd_pulse();
   endtask

   task automatic test_rx_random();
      logic [7:0] b;
      logic stop;
      int rise; bit dropped;
      for (int n = 0; n < 6; n++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_rx(b, stop, -1, rise, dropped);
         m_deliver(b, stop, 1'b0);
         rx_gap();
         checks++;
         if ({rx_data, rx_avail, rx_overrun, rx_frame_err} !== {m_data, m_avail, m_ovr, m_ferr}) begin
            errors++; $display("FAIL rx_random%0d: got %h, required %h", n,
                               {rx_data, rx_avail, rx_overrun, rx_frame_err}, {m_data, m_avail, m_ovr, m_ferr});
         end
         if ($urandom_range(0, 1) != 0) rd_pulse();
         if ($urandom_range(0, 3) == 0) err_pulse();
      end
      rd_pulse();
      err_pulse();
   endtask

   task automatic test_glitch_simul_break();
      logic [7:0] a, b;
      int d, rise; bit dropped;
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (400) @(negedge clk);
      checks++;
      if ({rx_avail, rx_overrun, rx_frame_err} !== 3'b000) begin
         errors++; $display("FAIL rx_glitch: got avail/ovr/ferr %b, required 000", {rx_avail, rx_overrun, rx_frame_err});
      end
      // Equal frame spacing keeps the baud-tick phase, so the delivery cycle of A predicts B's.
      a = 8'($urandom); b = 8'($urandom);
      send_rx(a, 1'b1, -1, d, dropped);
      m_deliver(a, 1'b1, 1'b0);
      rx_gap();
      send_rx(b, 1'b1, d - 1, rise, dropped);
      m_deliver(b, 1'b1, 1'b1);
      rx_gap();
      checks++;
      if (dropped || {rx_data, rx_avail, rx_overrun, rx_frame_err} !== {m_data, m_avail, m_ovr, m_ferr}) begin
         errors++; $display("FAIL rx_rd_simultaneous: got %h dropped=%0d, required %h dropped=0",
                            {rx_data, rx_avail, rx_overrun, rx_frame_err}, dropped, {m_data, m_avail, m_ovr, m_ferr});
      end
      rd_pulse();
      err_pulse();
      rxd = 1'b0;
      repeat (3 * FRAME) @(negedge clk);
      rxd = 1'b1;
      repeat (4 * BIT) @(negedge clk);
      m_deliver(8'h00, 1'b0, 1'b0);
      checks++;
      if ({rx_data, rx_avail, rx_overrun, rx_frame_err} !== {m_data, m_avail, m_ovr, m_ferr}) begin
         errors++; $display("FAIL rx_break: got %h, required %h", {rx_data, rx_avail, rx_overrun, rx_frame_err},
                            {m_data, m_avail, m_ovr, m_ferr});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] tb_byte, rb_byte, nb;
      int rise; bit dropped;
      tb_byte = 8'($urandom) & 8'hF7;
      rb_byte = 8'($urandom);
      for (int c = 0; c < 205; c++) begin
         rxd     = frame_level(rb_byte, 1'b1, c / BIT);
         tx_data = tb_byte;
         tx_wr   = (c == 64);
         @(negedge clk);
      end
      checks++;
      if (txd !== 1'b0) begin
         errors++; $display("FAIL tx_bit3_before_reset: got %b, required 0", txd);
      end
      reset = 1'b1; rxd = 1'b1; tx_wr = 1'b0;
      @(negedge clk);
      m_data = '0; m_avail = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      checks++;
      if ({txd, tx_empty, tx_all_sent, rx_data, rx_avail, rx_overrun, rx_frame_err} !== 14'b111_00000000_000) begin
         errors++; $display("FAIL reset_mid_frame: got %b, required 11100000000000",
                            {txd, tx_empty, tx_all_sent, rx_data, rx_avail, rx_overrun, rx_frame_err});
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4 * BIT) @(negedge clk);
      nb = 8'($urandom);
      send_rx(nb, 1'b1, -1, rise, dropped);
      m_deliver(nb, 1'b1, 1'b0);
      rx_gap();
      checks++;
      if ({txd, tx_empty, tx_all_sent, rx_data, rx_avail, rx_overrun, rx_frame_err} !==
          {3'b111, m_data, m_avail, m_ovr, m_ferr}) begin
         errors++; $display("FAIL after_reset_frame: got %h, required %h",
                            {txd, tx_empty, tx_all_sent, rx_data, rx_avail, rx_overrun, rx_frame_err},
                            {3'b111, m_data, m_avail, m_ovr, m_ferr});
      end
   endtask

   initial begin
      test_reset();
      test_single_tx();
      test_back_to_back();
      test_rx_loop();
      test_rx_overrun_frame();
      test_rx_random();
      test_glitch_simul_break();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
